// File: rtl/uc_pkg.sv
// Shared definitions for the unit-clause exchange: sizing, literal layout and transmitter states.
package uc_pkg;
   localparam int unsigned UC_LENGTH  = 1024;
   localparam int unsigned NUM_ENGINE = 4;
   localparam int unsigned IDX_W      = $clog2(UC_LENGTH);
   localparam int unsigned LIT_W      = IDX_W + 1;

   typedef struct packed {
      logic             polarity;
      logic [IDX_W-1:0] idx;
   } uc_lit_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HALT   = 2'd2
   } uc_tx_state_t;
endpackage

// File: rtl/uc_tx_fifo.sv
// Synchronous FIFO holding pending unit literals; flush empties it in one cycle.
module uc_tx_fifo #(
   parameter int unsigned W     = 11,
   parameter int unsigned DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at DEPTH; count carries the extra bit to tell full from empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/uc_eng_tx.sv
// Engine-side UC transmitter: buffers derived unit literals and retires one per arbiter grant window.
module uc_eng_tx #(
   parameter int unsigned UC_LENGTH  = 1024,
   parameter int unsigned NUM_ENGINE = 4,
   parameter int unsigned ENG_ID     = 0,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_done,
   input  logic                       eng_uc_valid,
   input  logic [$clog2(UC_LENGTH):0] eng_uc,
   output logic                       eng_uc_ready,
   input  logic [NUM_ENGINE-1:0]      engmask,
   input  logic                       conflict,
   output logic                       eng2uca_valid,
   output logic                       eng2uca_empty,
   output logic [$clog2(UC_LENGTH):0] eng2uca,
   output logic                       overflow,
   output logic                       halted
);
   import uc_pkg::*;

   localparam int unsigned LW = $clog2(UC_LENGTH) + 1;
   localparam int unsigned MW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

   uc_tx_state_t  state_q, state_d;
   logic          grant, grant_q;
   logic          offer_q, offer_d;
   logic          tail_vld_q, tail_vld_d;
   logic [LW-1:0] tail_q, tail_d;
   logic          overflow_d, halted_d;
   logic          live, dup, push, pop, flush;
   logic          full, empty;
   logic [LW-1:0] head;

   assign grant         = engmask[MW'(ENG_ID)];
   assign eng_uc_ready  = !full && (state_q != HALT);
   assign eng2uca_valid = offer_q;
   assign eng2uca_empty = !offer_q;
   assign eng2uca       = offer_q ? head : '0;

   uc_tx_fifo #(.W(LW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (eng_uc),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         grant_q    <= 1'b0;
         offer_q    <= 1'b0;
         tail_vld_q <= 1'b0;
         tail_q     <= '0;
         overflow   <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant;
         offer_q    <= offer_d;
         tail_vld_q <= tail_vld_d;
         tail_q     <= tail_d;
         overflow   <= overflow_d;
         halted     <= halted_d;
      end
   end

   // Next state, push/pop decisions and window bookkeeping; a conflict overrides everything else.
   always_comb begin
      state_d    = state_q;
      offer_d    = offer_q;
      tail_vld_d = tail_vld_q;
      tail_d     = tail_q;
      overflow_d = overflow;
      flush      = 1'b0;

      live = (state_q != HALT) && !conflict;
      dup  = tail_vld_q && (eng_uc == tail_q);
      push = live && eng_uc_valid && !dup && !full;
      pop  = live && offer_q && grant_q && !grant;

      case (state_q)
         IDLE: begin
            if (conflict)      state_d = HALT;
            else if (mem_done) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (conflict) state_d = HALT;
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase

      if (live && eng_uc_valid && !dup && full) overflow_d = 1'b1;

      if (push) begin
         tail_d     = eng_uc;
         tail_vld_d = 1'b1;
      end

      if (pop) offer_d = 1'b0;
      // The head is latched for the whole window only if something was queued when it opened.
      if (live && (state_q == ACTIVE) && grant && !grant_q && !empty) offer_d = 1'b1;

      if ((state_q != HALT) && conflict) begin
         flush      = 1'b1;
         offer_d    = 1'b0;
         tail_vld_d = 1'b0;
      end

      halted_d = (state_d == HALT);
   end
endmodule

// File: tb/tb_uc_eng_tx.sv
// Self-checking bench for uc_eng_tx: queue-based reference model, directed scenarios, random traffic.
module tb_uc_eng_tx;
   localparam int unsigned LW    = 11;
   localparam int unsigned NE    = 4;
   localparam int unsigned EID   = 1;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_done = 1'b0;
   logic          eng_uc_valid = 1'b0;
   logic [LW-1:0] eng_uc = '0;
   logic          eng_uc_ready;
   logic [NE-1:0] engmask = '0;
   logic          conflict = 1'b0;
   logic          eng2uca_valid;
   logic          eng2uca_empty;
   logic [LW-1:0] eng2uca;
   logic          overflow;
   logic          halted;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uc_eng_tx #(.UC_LENGTH(1024), .NUM_ENGINE(NE), .ENG_ID(EID), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_done      (mem_done),
      .eng_uc_valid  (eng_uc_valid),
      .eng_uc        (eng_uc),
      .eng_uc_ready  (eng_uc_ready),
      .engmask       (engmask),
      .conflict      (conflict),
      .eng2uca_valid (eng2uca_valid),
      .eng2uca_empty (eng2uca_empty),
      .eng2uca       (eng2uca),
      .overflow      (overflow),
      .halted        (halted)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 active, 2 halted; pending literals kept in a queue.
   int            mst;
   logic [LW-1:0] mq[$];
   logic          mtail_v, mgq, moffer, movf;
   logic [LW-1:0] mtail;

   always @(posedge clk or negedge rst) begin : model
      logic g, was_full, was_empty;
      if (!rst) begin
         mst = 0; mq.delete(); mtail_v = 1'b0; mtail = '0;
         mgq = 1'b0; moffer = 1'b0; movf = 1'b0;
      end else begin
         g = engmask[EID];
         if (mst != 2) begin
            if (conflict) begin
               mq.delete(); mtail_v = 1'b0; moffer = 1'b0; mst = 2;
            end else begin
               was_empty = (mq.size() == 0);
               was_full  = (mq.size() == DEPTH);
               if (g && !mgq && mst == 1 && !was_empty) moffer = 1'b1;
               else if (!g && mgq && moffer) begin
                  void'(mq.pop_front());
                  moffer = 1'b0;
               end
               if (eng_uc_valid && !(mtail_v && eng_uc == mtail)) begin
                  if (was_full) movf = 1'b1;
                  else begin
                     mq.push_back(eng_uc);
                     mtail = eng_uc; mtail_v = 1'b1;
                  end
               end
               if (mst == 0 && mem_done) mst = 1;
            end
         end
         mgq = g;
      end
   end

   always @(negedge clk) begin : compare
      logic [LW-1:0] exp_lit;
      exp_lit = moffer ? mq[0] : '0;
      chk("ready",    32'(eng_uc_ready),  32'(mst != 2 && mq.size() < DEPTH));
      chk("valid",    32'(eng2uca_valid), 32'(moffer));
      chk("empty",    32'(eng2uca_empty), 32'(!moffer));
      chk("lit",      32'(eng2uca),       32'(exp_lit));
      chk("overflow", 32'(overflow),      32'(movf));
      chk("halted",   32'(halted),        32'(mst == 2));
   end

   task automatic step(input logic v, input logic [LW-1:0] l, input logic g,
                       input logic md, input logic cf);
      eng_uc_valid = v;
      eng_uc       = l;
      engmask      = g ? NE'(1) << EID : '0;
      mem_done     = md;
      conflict     = cf;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      eng_uc_valid = 1'b0; eng_uc = '0; engmask = '0; mem_done = 1'b0; conflict = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #1;
      do_reset();
      chk("rst_ready", 32'(eng_uc_ready), 1);
      chk("rst_valid", 32'(eng2uca_valid), 0);
      chk("rst_empty", 32'(eng2uca_empty), 1);
      chk("rst_lit",   32'(eng2uca), 0);
      chk("rst_ovf",   32'(overflow), 0);
      chk("rst_halt",  32'(halted), 0);

      // Duplicate filter
      step(1, 11'h007, 0, 0, 0);
      step(1, 11'h007, 0, 0, 0);
      step(1, 11'h407, 0, 0, 0);
      step(0, 11'h000, 0, 1, 0);
      chk("dup_occ", 32'(mq.size()), 2);
      chk("dup_ovf", 32'(overflow), 0);
      step(0, 0, 1, 0, 0);
      chk("dup_lit0", 32'(eng2uca), 32'h007);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("dup_lit1", 32'(eng2uca), 32'h407);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("dup_drained", 32'(eng2uca_valid), 0);
      step(0, 0, 0, 0, 0);

      // Basic send
      do_reset();
      step(1, 11'h005, 0, 0, 0);
      step(1, 11'h40A, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      chk("basic_lit0", 32'(eng2uca), 32'h005);
      step(0, 0, 1, 0, 0);
      chk("basic_hold", 32'(eng2uca), 32'h005);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("basic_lit1", 32'(eng2uca), 32'h40A);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("basic_empty", 32'(eng2uca_empty), 1);

      // Empty grant with a push landing mid-window
      step(0, 0, 1, 0, 0);
      step(1, 11'h003, 1, 0, 0);
      chk("eg_valid0", 32'(eng2uca_valid), 0);
      step(0, 0, 0, 0, 0);
      chk("eg_valid1", 32'(eng2uca_valid), 0);
      step(0, 0, 1, 0, 0);
      chk("eg_lit", 32'(eng2uca), 32'h003);
      step(0, 0, 0, 0, 0);

      // Full / overflow
      do_reset();
      for (int i = 0; i < 16; i++) step(1, LW'(i), 0, 0, 0);
      chk("full_ready", 32'(eng_uc_ready), 0);
      step(1, LW'(16), 0, 0, 0);
      chk("full_ovf", 32'(overflow), 1);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1, 0, 0);
         chk("full_order", 32'(eng2uca), 32'(i));
         step(0, 0, 0, 0, 0);
      end
      step(0, 0, 1, 0, 0);
      chk("full_drained", 32'(eng2uca_valid), 0);
      step(0, 0, 0, 0, 0);

      // Push/pop collision at full
      do_reset();
      for (int i = 0; i < 16; i++) step(1, LW'(32'h100 + i), 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      chk("col_offer", 32'(eng2uca), 32'h100);
      step(1, 11'h011, 0, 0, 0);
      chk("col_ovf", 32'(overflow), 1);
      chk("col_ready", 32'(eng_uc_ready), 1);
      step(1, 11'h011, 0, 0, 0);
      chk("col_refull", 32'(eng_uc_ready), 0);
      chk("col_occ", 32'(mq.size()), 16);
      step(0, 0, 0, 0, 0);

      // Conflict mid-window
      do_reset();
      step(1, 11'h021, 0, 0, 0);
      step(1, 11'h022, 0, 0, 0);
      step(1, 11'h023, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      chk("cf_offer", 32'(eng2uca), 32'h021);
      step(0, 0, 1, 0, 1);
      chk("cf_halted", 32'(halted), 1);
      chk("cf_empty", 32'(eng2uca_empty), 1);
      chk("cf_ready", 32'(eng_uc_ready), 0);
      step(1, 11'h055, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("cf_quiet", 32'(eng2uca_valid), 0);
      chk("cf_still", 32'(halted), 1);

      // Reset asserted mid-window
      do_reset();
      step(1, 11'h031, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      chk("mr_offer", 32'(eng2uca_valid), 1);
      #2 rst = 1'b0;
      #1;
      chk("mr_valid", 32'(eng2uca_valid), 0);
      chk("mr_lit", 32'(eng2uca), 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Randomized traffic
      begin
         int unsigned chg_prob;
         chg_prob = 3;
         for (int c = 0; c < 6000; c++) begin
            if (c % 700 == 0) do_reset();
            if (c % 200 == 0) chg_prob = $urandom_range(2, 12);
            eng_uc_valid = 1'($urandom_range(0, 1));
            eng_uc       = {1'($urandom_range(0, 1)), 10'($urandom_range(0, 5))};
            if ($urandom_range(0, chg_prob) == 0) begin
               int unsigned k;
               k = $urandom_range(0, NE);
               engmask = (k == NE) ? '0 : NE'(1) << k;
            end
            mem_done = ($urandom_range(0, 29) == 0);
            conflict = ($urandom_range(0, 599) == 0);
            @(posedge clk);
            #1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
